// File: rtl/rng_hit_engine.sv
// rng_hit_engine: hit-resolution unit for the battle datapath.
// A free-running Galois LFSR (optionally stirred by an external entropy bit)
// supplies a roll on each accepted start. The roll is compared against a
// threshold, and on a hit saturating damage is applied to the HP register.
// The result is reported with a one-cycle done pulse.
//
// Optional feature macro: RNG_HIT_CRIT_EN
//   When defined, a hit whose two roll MSBs are 2'b11 is a critical hit.
//   A critical hit sets crit and doubles the damage, clamped to the HP range.
//   When undefined, crit is tied low and no extra logic is generated.
//
// Parameter constraints: RAND_W >= 4, TAPS != 0, SEED != 0, HP_INIT < 2**HP_W.
//
// FSM states:
//   state | meaning
//   IDLE  | ready=1; accepts load_hp (priority) or start
//   ROLL  | compare captured roll against the latched threshold
//   APPLY | apply saturating damage to hp when hit
//   DONE  | raise done for one cycle, return to IDLE

module rng_hit_engine #(
    parameter int                RAND_W  = 8,
    parameter logic [RAND_W-1:0] TAPS    = RAND_W'(8'hB8),
    parameter logic [RAND_W-1:0] SEED    = RAND_W'(8'h01),
    parameter int                HP_W    = 4,
    parameter int                HP_INIT = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entropy,
    input  logic              start,
    input  logic [RAND_W-1:0] threshold,
    input  logic [HP_W-1:0]   damage,
    input  logic              load_hp,
    input  logic [HP_W-1:0]   hp_in,
    output logic              ready,
    output logic              done,
    output logic [RAND_W-1:0] roll,
    output logic              hit,
    output logic              crit,
    output logic [HP_W-1:0]   hp,
    output logic              fainted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROLL  = 2'd1,
        APPLY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [RAND_W-1:0] lfsr;
    logic [RAND_W-1:0] lfsr_step;
    logic [RAND_W-1:0] lfsr_next;
    logic [RAND_W-1:0] threshold_q;
    logic [HP_W-1:0]   damage_q;
    logic [HP_W-1:0]   eff_dmg;
    logic [HP_W-1:0]   hp_sat;
    logic              roll_gt;

    // Galois step with entropy injection; an all-zero result reloads SEED
    always_comb begin
        lfsr_step    = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        lfsr_step[0] = lfsr_step[0] ^ entropy;
        lfsr_next    = (lfsr_step == '0) ? SEED : lfsr_step;
    end

    // LFSR runs every cycle independent of the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    assign roll_gt = (roll > threshold_q);

`ifdef RNG_HIT_CRIT_EN
    logic              crit_q;
    logic              crit_next;
    logic [HP_W:0]     dmg_dbl;

    assign crit      = crit_q;
    assign crit_next = roll_gt & (roll[RAND_W-1:RAND_W-2] == 2'b11);
    assign dmg_dbl   = {damage_q, 1'b0};

    // Critical hits double the damage; the extra bit catches overflow for the clamp
    always_comb begin
        eff_dmg = damage_q;
        if (crit_q) begin
            eff_dmg = dmg_dbl[HP_W] ? {HP_W{1'b1}} : dmg_dbl[HP_W-1:0];
        end
    end
`else
    assign crit    = 1'b0;
    assign eff_dmg = damage_q;
`endif

    // Saturating subtract: never wraps below zero
    assign hp_sat  = (hp > eff_dmg) ? (hp - eff_dmg) : '0;
    assign fainted = (hp == '0);

    // Sequencer: accept, compare, apply, report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            roll        <= '0;
            hit         <= 1'b0;
            hp          <= HP_W'(HP_INIT);
            threshold_q <= '0;
            damage_q    <= '0;
`ifdef RNG_HIT_CRIT_EN
            crit_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_hp) begin
                        hp <= hp_in;
                    end else if (start) begin
                        roll        <= lfsr;
                        threshold_q <= threshold;
                        damage_q    <= damage;
                        ready       <= 1'b0;
                        state       <= ROLL;
                    end
                end
                ROLL: begin
                    hit   <= roll_gt;
`ifdef RNG_HIT_CRIT_EN
                    crit_q <= crit_next;
`endif
                    state <= APPLY;
                end
                APPLY: begin
                    if (hit) begin
                        hp <= hp_sat;
                    end
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_hit_engine.sv
// Directed bench for rng_hit_engine: table of back-to-back rolls from reset
// plus hand-written sequences for load priority, busy-ignore, saturation,
// lock-up guard, asynchronous reset mid-operation and (optionally) crits.

module tb_rng_hit_engine;

    logic       clk;
    logic       reset;
    logic       entropy;
    logic       start;
    logic [7:0] threshold;
    logic [3:0] damage;
    logic       load_hp;
    logic [3:0] hp_in;
    logic       ready;
    logic       done;
    logic [7:0] roll;
    logic       hit;
    logic       crit;
    logic [3:0] hp;
    logic       fainted;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_lfsr;

    typedef struct {
        logic [7:0] th;
        logic [3:0] dmg;
        logic [7:0] exp_roll;
        logic       exp_hit;
        logic [3:0] exp_hp;
    } vec_t;

    vec_t vecs [8];

    rng_hit_engine dut (
        .clk       (clk),
        .reset     (reset),
        .entropy   (entropy),
        .start     (start),
        .threshold (threshold),
        .damage    (damage),
        .load_hp   (load_hp),
        .hp_in     (hp_in),
        .ready     (ready),
        .done      (done),
        .roll      (roll),
        .hit       (hit),
        .crit      (crit),
        .hp        (hp),
        .fainted   (fainted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_f(input logic [7:0] s, input logic e);
        logic [7:0] n;
        n    = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
        n[0] = n[0] ^ e;
        return (n == 8'h00) ? 8'h01 : n;
    endfunction

    // Reference LFSR, used to steer the lock-up and crit sequences
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'h01;
        else       m_lfsr <= lfsr_f(m_lfsr, entropy);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},   32'(ready),   32'd1);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_roll"},    32'(roll),    32'd0);
        chk({tag, "_hit"},     32'(hit),     32'd0);
        chk({tag, "_crit"},    32'(crit),    32'd0);
        chk({tag, "_hp"},      32'(hp),      32'd9);
        chk({tag, "_fainted"}, 32'(fainted), 32'd0);
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge where done is high
    task automatic do_roll(input logic [7:0] th, input logic [3:0] dmg);
        int n;
        threshold = th;
        damage    = dmg;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic load(input logic [3:0] v);
        load_hp = 1'b1;
        hp_in   = v;
        @(posedge clk);
        @(negedge clk);
        load_hp = 1'b0;
    endtask

    initial begin
        int n;
        int dcount;

        // Rolls captured back-to-back from reset with entropy=0:
        // LFSR states 01,17,64,5A,93,30,03,39 at accept edges 0,4,8,...
        vecs[0] = '{8'h00, 4'd2, 8'h01, 1'b1, 4'd7};
        vecs[1] = '{8'hFF, 4'd3, 8'h17, 1'b0, 4'd7};
        vecs[2] = '{8'h63, 4'd1, 8'h64, 1'b1, 4'd6};
        vecs[3] = '{8'h5A, 4'd4, 8'h5A, 1'b0, 4'd6};
        vecs[4] = '{8'h80, 4'd0, 8'h93, 1'b1, 4'd6};
        vecs[5] = '{8'h2F, 4'd5, 8'h30, 1'b1, 4'd1};
        vecs[6] = '{8'h00, 4'd4, 8'h03, 1'b1, 4'd0};
        vecs[7] = '{8'h00, 4'd1, 8'h39, 1'b1, 4'd0};

        reset     = 1'b1;
        entropy   = 1'b0;
        start     = 1'b0;
        threshold = 8'h00;
        damage    = 4'd0;
        load_hp   = 1'b0;
        hp_in     = 4'd0;

        @(negedge clk);
        chk_reset_vals("rst");

        // Release reset and request immediately; start held across all vectors
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            threshold = vecs[i].th;
            damage    = vecs[i].dmg;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk);
                @(negedge clk);
                chk("busy_ready", 32'(ready), 32'd0);
                chk("busy_done",  32'(done),  32'd0);
            end
            @(posedge clk);
            @(negedge clk);
            chk("vec_done",    32'(done),    32'd1);
            chk("vec_ready",   32'(ready),   32'd1);
            chk("vec_roll",    32'(roll),    32'(vecs[i].exp_roll));
            chk("vec_hit",     32'(hit),     32'(vecs[i].exp_hit));
            chk("vec_hp",      32'(hp),      32'(vecs[i].exp_hp));
            chk("vec_fainted", 32'(fainted), 32'(vecs[i].exp_hp == 4'd0));
            chk("vec_crit",    32'(crit),    32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);

        // load_hp wins over start in the same IDLE cycle
        load_hp   = 1'b1;
        hp_in     = 4'd6;
        start     = 1'b1;
        threshold = 8'h00;
        damage    = 4'd1;
        @(posedge clk);
        @(negedge clk);
        load_hp = 1'b0;
        start   = 1'b0;
        chk("prio_hp", 32'(hp), 32'd6);
        dcount = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("prio_no_done", 32'(dcount), 32'd0);
        chk("prio_ready",   32'(ready),  32'd1);

        // load_hp while busy is ignored
        threshold = 8'hFF;
        damage    = 4'd1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        load_hp = 1'b1;
        hp_in   = 4'd1;
        @(posedge clk);
        @(negedge clk);
        load_hp = 1'b0;
        n = 0;
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("busy_load_done", 32'(done), 32'd1);
        chk("busy_load_hp",   32'(hp),   32'd6);
        chk("busy_load_hit",  32'(hit),  32'd0);

        // Asynchronous reset while in APPLY
        @(negedge clk);
        threshold = 8'h00;
        damage    = 4'd1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);

        // No-hit with threshold all-ones
        for (int r = 0; r < 5; r++) begin
            do_roll(8'hFF, 4'd3);
            chk("nohit_hit",  32'(hit),          32'd0);
            chk("nohit_hp",   32'(hp),           32'd9);
            chk("nohit_roll", 32'(roll != 8'h00), 32'd1);
        end

        // Saturation at zero
        @(negedge clk);
        load(4'd3);
        chk("load_hp", 32'(hp), 32'd3);
        do_roll(8'h00, 4'd5);
        chk("sat_hit",     32'(hit),     32'd1);
        chk("sat_hp",      32'(hp),      32'd0);
        chk("sat_fainted", 32'(fainted), 32'd1);
        @(negedge clk);
        do_roll(8'h00, 4'd5);
        chk("sat2_hit", 32'(hit), 32'd1);
        chk("sat2_hp",  32'(hp),  32'd0);

        // Lock-up guard: lfsr=02 with entropy=1 would give zero
        entropy = 1'b0;
        n = 0;
        while (m_lfsr != 8'h02 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("lockup_reach", 32'(m_lfsr), 32'h02);
        entropy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        entropy = 1'b0;
        do_roll(8'h00, 4'd0);
        chk("lockup_roll", 32'(roll), 32'h01);

        // Random entropy: roll never zero, threshold 0 always hits
        @(negedge clk);
        threshold = 8'h00;
        damage    = 4'd0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (done) begin
                chk("rand_roll_nz", 32'(roll != 8'h00), 32'd1);
                chk("rand_hit",     32'(hit),           32'd1);
            end
            entropy = 1'($urandom_range(0, 1));
            start   = 1'b1;
        end
        start   = 1'b0;
        entropy = 1'b0;
        repeat (6) @(negedge clk);
        chk("rand_idle", 32'(ready), 32'd1);

`ifdef RNG_HIT_CRIT_EN
        // Critical hits: roll MSBs 11 doubles damage, clamped to 15
        load(4'd9);
        n = 0;
        while (m_lfsr[7:6] != 2'b11 && n < 300) begin
            @(negedge clk);
            n++;
        end
        do_roll(8'h00, 4'd3);
        chk("crit_flag", 32'(crit), 32'd1);
        chk("crit_hp",   32'(hp),   32'd3);
        @(negedge clk);
        load(4'd9);
        n = 0;
        while (m_lfsr[7:6] != 2'b11 && n < 300) begin
            @(negedge clk);
            n++;
        end
        do_roll(8'h00, 4'd8);
        chk("crit_clamp_flag", 32'(crit), 32'd1);
        chk("crit_clamp_hp",   32'(hp),   32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_hit_engine.md
Name: rng_hit_engine

Overview:
- Parametrised hit-resolution unit for the battle datapath.
- Holds a free-running Galois LFSR, optionally stirred by an external entropy bit such as a ring-oscillator sampler output.
- On each start request it draws a roll, compares it against a threshold, and applies saturating damage to an HP register.
- Reports the result with a one-cycle done pulse. It replaces the fixed 4-bit "roll > 7 then HP minus 1" logic, and its outputs feed the hex display and LED logic.

Parameters:
- RAND_W, 8, LFSR and roll width in bits (min 4).
- TAPS, 8'hB8, Galois feedback mask, RAND_W bits; must be non-zero.
- SEED, 8'h01, LFSR reset value, RAND_W bits; must be non-zero.
- HP_W, 4, HP register and damage width in bits.
- HP_INIT, 9, HP reset value; must be below 2^HP_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  Asynchronous, active-high reset; clears all state immediately.
- entropy  in  1  external random bit, XORed into the LFSR each cycle; tie to 0 for deterministic operation.
- start  in  1  roll request; accepted only while ready=1.
- threshold  in  RAND_W  a hit occurs when roll > threshold (unsigned); sampled on the start-accept edge.
- damage  in  HP_W  HP decrement applied on a hit; sampled on the start-accept edge.
- load_hp  in  1  loads hp_in into HP; honoured only while ready=1.
- hp_in  in  HP_W  HP load value.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse; roll, hit, crit and hp are valid in the same cycle.
- roll  out  RAND_W  captured roll; held until the next accept.
- hit  out  1  registered compare result; held.
- crit  out  1  critical-hit flag; held. Constant 0 without CRIT_EN.
- hp  out  HP_W  current HP.
- fainted  out  1  high whenever hp==0; decoded from the HP register.

Behaviour:
- Reset values: lfsr=SEED, state=IDLE, ready=1, done=0, roll=0, hit=0, crit=0, hp=HP_INIT, fainted=(HP_INIT==0).
- LFSR step, every clock edge regardless of FSM state:
  - n = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0);
  - n[0] ^= entropy;
  - if n==0, load SEED instead (no lock-up).
- FSM: IDLE -> ROLL -> APPLY -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - load_hp=1: hp<=hp_in; any start in the same cycle is ignored (load wins).
  - Otherwise start=1: roll<=current lfsr (the pre-edge value); threshold and damage latched; go to ROLL.
- ROLL: hit<=(roll>threshold_q); crit computed; go to APPLY.
- APPLY:
  - If hit, hp<=(hp>eff_dmg) ? hp-eff_dmg : 0, saturating at 0 with no wrap.
  - eff_dmg is damage_q, or as extended by CRIT_EN.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Latency: start accepted on edge 0; done high in the cycle after edge 3. Back-to-back throughput is one roll per 4 cycles.
- start or load_hp while ready=0: ignored, not queued.
- fainted=1: rolls still resolve and hit is reported; hp stays 0.
- damage=0: a hit is reported and hp is unchanged.
- threshold = all-ones: a hit is impossible. threshold=0: always a hit, since roll is never 0.
- Reset asserted mid-operation: the operation is aborted, all state returns to reset values, and done is not issued.

Optional Feature:
- Macro: RNG_HIT_CRIT_EN.
- When defined:
  - In ROLL, crit<=hit & (roll[RAND_W-1:RAND_W-2]==2'b11).
  - In APPLY, eff_dmg=min(2*damage_q, 2^HP_W-1); the doubling is computed at HP_W+1 bits, then clamped.
- When undefined: crit is tied to 0, eff_dmg=damage_q, and no extra logic is generated.

Test Plan:
- Deterministic sequence:
  - Stimulus: reset pulse, entropy=0, defaults; start=1 in the first cycle after reset release, threshold=0, damage=2.
  - Required response: roll=8'h01, hit=1, hp=7, done high exactly 4 edges after accept, ready low during ROLL/APPLY/DONE.
  - Then hold start=1 continuously: the next accept occurs one cycle after done.
- No-hit and saturation:
  - Stimulus: threshold=8'hFF, 5 rolls.
  - Required response: hit=0, hp stays 9.
  - Then load_hp with hp_in=3, threshold=0, damage=5.
  - Required response: hp=0, fainted=1. One further roll gives hit=1, hp=0, no wrap to 15.
- Priority and busy-ignore:
  - Stimulus: load_hp=1, hp_in=6 and start=1 in the same IDLE cycle.
  - Required response: hp=6, no done.
  - Stimulus: load_hp pulse during ROLL.
  - Required response: hp unchanged.
- Lock-up guard:
  - Stimulus: drive entropy so that n==0 would be produced.
  - Required response: lfsr takes SEED. Over 1000 random-entropy cycles, roll is never 0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while the FSM is in APPLY.
  - Required response: outputs return to reset values immediately (hp=9, roll=0, ready=1), and no done pulse follows.
- CRIT_EN build:
  - Stimulus: threshold=0, damage=3, hp=9, with a roll whose top bits are 2'b11.
  - Required response: crit=1, hp=3.
  - Stimulus: damage=8 with a crit.
  - Required response: eff_dmg clamps to 15, hp=0.
